jk_count_sequencer: RTL and testbench

//   Controller for a WIDTH-bit synchronous JK-flip-flop counter.
//   - Sequences the counter: load, count up or down, pause, abort,

---
 rtl/jk_count_sequencer.sv | 157 +++++++++++++++
 tb/tb_jk_count_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/jk_count_sequencer.sv
// Sequencer around a WIDTH-bit synchronous JK counter: load, count up/down, pause, abort, auto-reload.
// Define JKC_PRESCALE_EN to step only on every PRESCALE-th RUN cycle.
module jk_count_sequencer #(
  parameter int WIDTH    = 2,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             dir,
  input  logic             reload,
  input  logic [WIDTH-1:0] load_val,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] load_q, load_d;
  logic             dir_q, dir_d;
  logic             rel_q, rel_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] jk_mask;
  logic             at_term;
  logic             presc_hit;
  logic             run_step;
  logic             count_step;

`ifdef JKC_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] presc_q, presc_d;
  assign presc_hit = (presc_q == PW'(PRESCALE - 1));
`else
  // Every RUN cycle is a step cycle; PRESCALE has no effect in this build.
  assign presc_hit = (PRESCALE != 0);
`endif

  assign term    = dir_q ? '1 : '0;
  assign at_term = (q_q == term);

  // Bit i toggles when every lower bit is 1 (up) or 0 (down).
  always_comb begin
    logic carry;
    jk_mask = '0;
    carry   = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      jk_mask[i] = carry;
      carry      = carry & (dir_q ? q_q[i] : ~q_q[i]);
    end
  end

  assign run_step   = (state_q == RUN) & ~abort & ~pause & presc_hit;
  assign count_step = run_step & ~at_term;

  assign j    = count_step ? jk_mask : '0;
  assign k    = count_step ? jk_mask : '0;
  assign q    = q_q;
  assign busy = (state_q == RUN) | (state_q == HOLD);
  assign tc   = busy & at_term;
  assign done = done_q;

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    load_d  = load_q;
    dir_d   = dir_q;
    rel_d   = rel_q;
    done_d  = 1'b0;
`ifdef JKC_PRESCALE_EN
    presc_d = presc_q;
`endif
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          q_d     = load_val;
          load_d  = load_val;
          dir_d   = dir;
          rel_d   = reload;
          state_d = RUN;
`ifdef JKC_PRESCALE_EN
          presc_d = '0;
`endif
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
`ifdef JKC_PRESCALE_EN
          presc_d = '0;
`endif
        end else if (pause) begin
          state_d = HOLD;
        end else if (presc_hit) begin
`ifdef JKC_PRESCALE_EN
          presc_d = '0;
`endif
          if (!at_term) begin
            q_d = q_q ^ jk_mask;
          end else begin
            done_d = 1'b1;
            if (rel_q) q_d = load_q;
            else       state_d = IDLE;
          end
        end else begin
`ifdef JKC_PRESCALE_EN
          presc_d = presc_q + 1'b1;
`endif
        end
      end
      HOLD: begin
        if (abort) begin
          state_d = IDLE;
`ifdef JKC_PRESCALE_EN
          presc_d = '0;
`endif
        end else if (!pause) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      q_q     <= '0;
      load_q  <= '0;
      dir_q   <= 1'b0;
      rel_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef JKC_PRESCALE_EN
      presc_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      load_q  <= load_d;
      dir_q   <= dir_d;
      rel_q   <= rel_d;
      done_q  <= done_d;
`ifdef JKC_PRESCALE_EN
      presc_q <= presc_d;
`endif
    end
  end

endmodule

// File: tb/tb_jk_count_sequencer.sv
// Self-checking bench for jk_count_sequencer: directed scenarios plus randomized traffic against a reference model.
module tb_jk_count_sequencer;
  localparam int W    = 2;
  localparam int MAXV = (1 << W) - 1;
`ifdef JKC_PRESCALE_EN
  localparam int PS = 4;
`endif

  logic         clk = 1'b0;
  logic         reset, start, dir, reload, pause, abort;
  logic [W-1:0] load_val, q, j, k;
  logic         busy, tc, done;

  int n_vec = 0;
  int n_err = 0;

  // reference model: m_st 0=idle, 1=running, 2=held
  int m_st = 0, m_q = 0, m_dir = 0, m_rel = 0, m_load = 0, m_done = 0, m_pc = 0;

  jk_count_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .dir(dir), .reload(reload),
    .load_val(load_val), .pause(pause), .abort(abort),
    .q(q), .j(j), .k(k), .busy(busy), .tc(tc), .done(done)
  );

  always #5 clk = ~clk;

  function automatic int m_term();
    return m_dir != 0 ? MAXV : 0;
  endfunction

  function automatic bit m_hit();
`ifdef JKC_PRESCALE_EN
    return m_pc == PS - 1;
`else
    return 1'b1;
`endif
  endfunction

  function automatic int m_next(int v);
    return m_dir != 0 ? (v + 1) & MAXV : (v + MAXV) & MAXV;
  endfunction

  // toggle mask = bits that differ between the value and its successor
  function automatic logic [W-1:0] m_jk();
    if (m_st == 1 && !abort && !pause && m_hit() && m_q != m_term())
      return W'(m_q ^ m_next(m_q));
    return '0;
  endfunction

  task automatic tick();
    int nd;
    @(posedge clk);
    nd = 0;
    if (reset) begin
      m_st = 0; m_q = 0; m_dir = 0; m_rel = 0; m_load = 0; m_pc = 0;
    end else begin
      case (m_st)
        0: if (start && !abort) begin
             m_q = load_val; m_load = load_val; m_dir = dir; m_rel = reload; m_st = 1; m_pc = 0;
           end
        1: if (abort) begin m_st = 0; m_pc = 0; end
           else if (pause) m_st = 2;
           else if (m_hit()) begin
             m_pc = 0;
             if (m_q != m_term()) m_q = m_next(m_q);
             else begin nd = 1; if (m_rel != 0) m_q = m_load; else m_st = 0; end
           end else m_pc++;
        default: if (abort) begin m_st = 0; m_pc = 0; end
                 else if (!pause) m_st = 1;
      endcase
    end
    m_done = nd;
    @(negedge clk);
  endtask

  task automatic set_in(input bit s, input bit d, input bit r, input logic [W-1:0] lv,
                        input bit p, input bit a);
    start = s; dir = d; reload = r; load_val = lv; pause = p; abort = a;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
    tick(); tick();
    n_vec++; if (q !== '0)   begin n_err++; $display("FAIL reset_q actual=%0d required=0", q); end
    n_vec++; if (busy !== 0) begin n_err++; $display("FAIL reset_busy actual=%b required=0", busy); end
    n_vec++; if (done !== 0) begin n_err++; $display("FAIL reset_done actual=%b required=0", done); end
    n_vec++; if (tc !== 0)   begin n_err++; $display("FAIL reset_tc actual=%b required=0", tc); end
    reset = 1'b0;
    #1;
  endtask

`ifndef JKC_PRESCALE_EN
  task automatic test_count_down();
    set_in(1, 0, 0, 3, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (q !== W'(3 - i)) begin n_err++; $display("FAIL down_q step=%0d actual=%0d required=%0d", i, q, 3 - i); end
      n_vec++; if (busy !== 1 || done !== 0) begin n_err++; $display("FAIL down_busy step=%0d actual=%b%b required=10", i, busy, done); end
      n_vec++; if (tc !== (i == 3)) begin n_err++; $display("FAIL down_tc step=%0d actual=%b required=%b", i, tc, i == 3); end
      tick();
    end
    n_vec++; if (done !== 1 || busy !== 0) begin n_err++; $display("FAIL down_end actual=done%b busy%b required=done1 busy0", done, busy); end
    tick();
    n_vec++; if (done !== 0 || q !== '0) begin n_err++; $display("FAIL down_after actual=done%b q%0d required=done0 q0", done, q); end
  endtask

  task automatic test_reload_up();
    set_in(1, 1, 1, 1, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      n_vec++; if (q !== W'(1 + i % 3)) begin n_err++; $display("FAIL reload_q cyc=%0d actual=%0d required=%0d", i, q, 1 + i % 3); end
      n_vec++; if (done !== (i > 0 && i % 3 == 0)) begin n_err++; $display("FAIL reload_done cyc=%0d actual=%b required=%b", i, done, i > 0 && i % 3 == 0); end
      if (i % 3 == 0) begin
        n_vec++; if (j !== 2'b11 || k !== 2'b11) begin n_err++; $display("FAIL reload_jk cyc=%0d actual=%b/%b required=11/11", i, j, k); end
      end
      tick();
    end
    set_in(0, 0, 0, 0, 0, 1);
    tick();
    set_in(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_pause();
    set_in(1, 0, 0, 3, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (j !== '0 || k !== '0) begin n_err++; $display("FAIL pause_jk cyc=%0d actual=%b/%b required=00/00", i, j, k); end
      tick();
      n_vec++; if (q !== 2'd2 || busy !== 1) begin n_err++; $display("FAIL pause_hold cyc=%0d actual=q%0d busy%b required=q2 busy1", i, q, busy); end
    end
    set_in(0, 0, 0, 0, 0, 0);
    tick();
    n_vec++; if (q !== 2'd2) begin n_err++; $display("FAIL pause_release actual=%0d required=2", q); end
    tick();
    n_vec++; if (q !== 2'd1) begin n_err++; $display("FAIL pause_resume1 actual=%0d required=1", q); end
    tick();
    n_vec++; if (q !== 2'd0) begin n_err++; $display("FAIL pause_resume0 actual=%0d required=0", q); end
    tick();
    n_vec++; if (done !== 1 || busy !== 0) begin n_err++; $display("FAIL pause_done actual=done%b busy%b required=done1 busy0", done, busy); end
  endtask

  task automatic test_abort();
    set_in(1, 0, 0, 3, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    tick(); tick();
    set_in(0, 0, 0, 0, 0, 1);
    tick();
    n_vec++; if (busy !== 0 || q !== 2'd1) begin n_err++; $display("FAIL abort_idle actual=busy%b q%0d required=busy0 q1", busy, q); end
    set_in(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (done !== 0) begin n_err++; $display("FAIL abort_done cyc=%0d actual=%b required=0", i, done); end
      tick();
    end
    set_in(1, 1, 0, 0, 0, 1);
    tick();
    n_vec++; if (busy !== 0 || q !== 2'd1) begin n_err++; $display("FAIL start_abort actual=busy%b q%0d required=busy0 q1", busy, q); end
    set_in(0, 0, 0, 0, 0, 0);
  endtask
`else
  task automatic test_prescale();
    int first_done;
    first_done = -1;
    set_in(1, 0, 0, 2, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (n == 3) begin
        n_vec++; if (q !== 2'd2) begin n_err++; $display("FAIL presc_q3 actual=%0d required=2", q); end
      end
      if (n == 4) begin
        n_vec++; if (q !== 2'd1) begin n_err++; $display("FAIL presc_q4 actual=%0d required=1", q); end
      end
      if (n == 8) begin
        n_vec++; if (q !== 2'd0) begin n_err++; $display("FAIL presc_q8 actual=%0d required=0", q); end
      end
      if (done === 1 && first_done < 0) first_done = n;
    end
    n_vec++; if (first_done != 12) begin n_err++; $display("FAIL presc_done_lat actual=%0d required=12", first_done); end
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      reset = ($urandom_range(0, 59) == 0);
      set_in($urandom_range(0, 2) == 0, 1'($urandom), 1'($urandom), W'($urandom),
             $urandom_range(0, 5) == 0, $urandom_range(0, 24) == 0);
      n_vec++; if (q !== W'(m_q)) begin n_err++; $display("FAIL rnd_q cyc=%0d actual=%0d required=%0d", c, q, m_q); end
      n_vec++; if (busy !== (m_st != 0)) begin n_err++; $display("FAIL rnd_busy cyc=%0d actual=%b required=%b", c, busy, m_st != 0); end
      n_vec++; if (tc !== (m_st != 0 && m_q == m_term())) begin n_err++; $display("FAIL rnd_tc cyc=%0d actual=%b required=%b", c, tc, m_st != 0 && m_q == m_term()); end
      n_vec++; if (done !== (m_done != 0)) begin n_err++; $display("FAIL rnd_done cyc=%0d actual=%b required=%b", c, done, m_done != 0); end
      n_vec++; if (j !== m_jk() || k !== m_jk()) begin n_err++; $display("FAIL rnd_jk cyc=%0d actual=%b/%b required=%b", c, j, k, m_jk()); end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    test_reset();
`ifndef JKC_PRESCALE_EN
    test_count_down();
    test_reload_up();
    test_pause();
    test_abort();
`else
    test_prescale();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
